// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: arbitrates NMI/IRQ/BRK at an instruction boundary and
// drives the 7-cycle stack-push and vector-fetch sequence onto the CPU bus.
module interrupt_sequencer #(
  parameter logic [15:0] NMI_VECTOR = 16'hFFFA,
  parameter logic [15:0] IRQ_VECTOR = 16'hFFFE,
  parameter logic [7:0]  STACK_PAGE = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enableFFs,
  input  logic        fetchBoundary,
  input  logic        brkDecoded,
  input  logic        irqGenerated,
  input  logic        nmiGenerated,
  input  logic        processStatusRegIFlag,
  input  logic [15:0] pcIn,
  input  logic [7:0]  psrIn,
  input  logic [7:0]  spIn,
  input  logic [7:0]  dataBusIn,
  output logic [15:0] addrOut,
  output logic [7:0]  dataOut,
  output logic        writeEn,
  output logic        spDecrement,
  output logic        pcLoadLow,
  output logic        pcLoadHigh,
  output logic        setIFlag,
  output logic        interruptAcknowleged,
  output logic        nmiAcknowleged,
  output logic        sequenceActive
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DUMMY    = 3'd1;
  localparam logic [2:0] PUSH_PCH = 3'd2;
  localparam logic [2:0] PUSH_PCL = 3'd3;
  localparam logic [2:0] PUSH_P   = 3'd4;
  localparam logic [2:0] VEC_LO   = 3'd5;
  localparam logic [2:0] VEC_HI   = 3'd6;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_NMI  = 2'd1;
  localparam logic [1:0] SRC_IRQ  = 2'd2;
  localparam logic [1:0] SRC_BRK  = 2'd3;

  logic [2:0]  stateReg, stateNext;
  logic [1:0]  sourceReg, sourceNext, sourceEff;
  logic        brkReg, brkNext;
  logic [15:0] addrReg, addrComb, vector;
  logic [7:0]  dataReg, dataComb, pushedPsr;
  logic        hijack;
  logic        writeComb, spDecComb, pclComb, pchComb, setIComb, irqAckComb, nmiAckComb;
  logic        live;

  // The read data is consumed by the PC registers in the datapath, not here.
  logic unusedDataBus;
  assign unusedDataBus = ^dataBusIn;

  always_comb begin
    hijack = 1'b0;
    if (nmiGenerated && (sourceReg != SRC_NMI) &&
        ((stateReg == DUMMY) || (stateReg == PUSH_PCH) ||
         (stateReg == PUSH_PCL) || (stateReg == PUSH_P)))
      hijack = 1'b1;
    sourceEff = hijack ? SRC_NMI : sourceReg;
    vector    = (sourceReg == SRC_NMI) ? NMI_VECTOR : IRQ_VECTOR;
    // B reflects the original source even after an NMI hijack.
    pushedPsr = (psrIn & 8'hCF) | 8'h20 | (brkReg ? 8'h10 : 8'h00);

    stateNext  = stateReg;
    sourceNext = sourceEff;
    brkNext    = brkReg;
    addrComb   = 16'h0000;
    dataComb   = 8'h00;
    writeComb  = 1'b0;
    spDecComb  = 1'b0;
    pclComb    = 1'b0;
    pchComb    = 1'b0;
    setIComb   = 1'b0;
    irqAckComb = 1'b0;
    nmiAckComb = 1'b0;

    case (stateReg)
      IDLE: begin
        sourceNext = SRC_NONE;
        brkNext    = 1'b0;
        if (fetchBoundary && nmiGenerated) begin
          sourceNext = SRC_NMI;
          stateNext  = DUMMY;
        end else if (fetchBoundary && irqGenerated && !processStatusRegIFlag) begin
          sourceNext = SRC_IRQ;
          stateNext  = DUMMY;
        end else if (brkDecoded) begin
          sourceNext = SRC_BRK;
          brkNext    = 1'b1;
          stateNext  = DUMMY;
        end
      end
      DUMMY: begin
        addrComb  = pcIn;
        stateNext = PUSH_PCH;
      end
      PUSH_PCH: begin
        addrComb  = {STACK_PAGE, spIn};
        dataComb  = pcIn[15:8];
        writeComb = 1'b1;
        spDecComb = 1'b1;
        stateNext = PUSH_PCL;
      end
      PUSH_PCL: begin
        addrComb  = {STACK_PAGE, spIn};
        dataComb  = pcIn[7:0];
        writeComb = 1'b1;
        spDecComb = 1'b1;
        stateNext = PUSH_P;
      end
      PUSH_P: begin
        addrComb   = {STACK_PAGE, spIn};
        dataComb   = pushedPsr;
        writeComb  = 1'b1;
        spDecComb  = 1'b1;
        setIComb   = 1'b1;
        irqAckComb = (sourceEff == SRC_IRQ);
        nmiAckComb = (sourceEff == SRC_NMI);
        stateNext  = VEC_LO;
      end
      VEC_LO: begin
        addrComb  = vector;
        pclComb   = 1'b1;
        stateNext = VEC_HI;
      end
      VEC_HI: begin
        addrComb   = vector + 16'd1;
        pchComb    = 1'b1;
        stateNext  = IDLE;
        sourceNext = SRC_NONE;
        brkNext    = 1'b0;
      end
      default: begin
        stateNext  = IDLE;
        sourceNext = SRC_NONE;
        brkNext    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg  <= IDLE;
      sourceReg <= SRC_NONE;
      brkReg    <= 1'b0;
      addrReg   <= 16'h0000;
      dataReg   <= 8'h00;
    end else if (enableFFs) begin
      stateReg  <= stateNext;
      sourceReg <= sourceNext;
      brkReg    <= brkNext;
      addrReg   <= addrComb;
      dataReg   <= dataComb;
    end
  end

  // Strobes fire only on enabled, non-reset cycles so an aborted entry never acknowledges.
  assign live = enableFFs && !rst;

  assign addrOut              = rst ? 16'h0000 : (enableFFs ? addrComb : addrReg);
  assign dataOut              = rst ? 8'h00 : (enableFFs ? dataComb : dataReg);
  assign writeEn              = live && writeComb;
  assign spDecrement          = live && spDecComb;
  assign pcLoadLow            = live && pclComb;
  assign pcLoadHigh           = live && pchComb;
  assign setIFlag             = live && setIComb;
  assign interruptAcknowleged = live && irqAckComb;
  assign nmiAcknowleged       = live && nmiAckComb;
  assign sequenceActive       = !rst && (stateReg != IDLE);

endmodule
